// File: rtl/processador_pkg.sv
// Shared types and constants for the processor's decimal input path.
package processador_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} estado_e;

  localparam int unsigned NUM_DIGITOS = 3;
  localparam int unsigned BCD_W       = 4 * NUM_DIGITOS;
  localparam int unsigned BIN_W       = 10;
  localparam int unsigned ITERACOES   = 10;
  localparam int unsigned CNT_W       = $clog2(ITERACOES);

  localparam logic [3:0] BCD_MAX     = 4'd9;
  // Display blank code; anything above BCD_MAX, this included, is an invalid digit.
  localparam logic [3:0] BCD_APAGADO = 4'd11;

  function automatic logic digito_valido(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_ajuste.sv
// Single-digit correction step of reverse double-dabble: digits >= 8 lose 3 after a shift.
module bcd_ajuste (
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o
);

  assign digito_o = (digito_i >= 4'd8) ? (digito_i - 4'd3) : digito_i;

endmodule

// File: rtl/bcd_para_binario.sv
// Sequential three-digit signed BCD to two's-complement converter, one shift per clock.
module bcd_para_binario
  import processador_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sinal,
  input  logic [3:0]        centena,
  input  logic [3:0]        dezena,
  input  logic [3:0]        unidade,
  output logic [DATA_W-1:0] numero,
  output logic              busy,
  output logic              done,
  output logic              erro
);

  estado_e             state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                sinal_q, sinal_d;
  logic [DATA_W-1:0]   numero_q, numero_d;
  logic                done_q, done_d;
  logic                erro_q, erro_d;

  logic [BCD_W-1:0]    bcd_sh, bcd_aj;
  logic [BIN_W-1:0]    bin_sh;
  logic [DATA_W-1:0]   bin_ext;
  logic                digitos_ok;

  assign {bcd_sh, bin_sh} = {bcd_q, bin_q} >> 1;
  assign bin_ext          = {{(DATA_W - BIN_W){1'b0}}, bin_q};
  assign digitos_ok       = digito_valido(centena) && digito_valido(dezena) &&
                            digito_valido(unidade);

  for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_ajuste
    bcd_ajuste u_ajuste (
      .digito_i(bcd_sh[4*i +: 4]),
      .digito_o(bcd_aj[4*i +: 4])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    sinal_d  = sinal_q;
    numero_d = numero_q;
    done_d   = 1'b0;
    erro_d   = erro_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (digitos_ok) begin
            bcd_d   = {centena, dezena, unidade};
            bin_d   = '0;
            cnt_d   = '0;
            sinal_d = sinal;
            erro_d  = 1'b0;
            state_d = SHIFT;
          end else begin
            // Rejected request: flag it and pulse done, result untouched.
            erro_d = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_aj;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERACOES - 1)) state_d = FIN;
      end
      FIN: begin
        numero_d = sinal_q ? ('0 - bin_ext) : bin_ext;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
      sinal_q  <= 1'b0;
      numero_q <= '0;
      done_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      sinal_q  <= sinal_d;
      numero_q <= numero_d;
      done_q   <= done_d;
      erro_q   <= erro_d;
    end
  end

  assign numero = numero_q;
  assign done   = done_q;
  assign erro   = erro_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_para_binario.sv
// Directed bench for bcd_para_binario with a queue-based scoreboard of expected results.
module tb_bcd_para_binario;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sinal;
  logic [3:0]  centena, dezena, unidade;
  logic [31:0] numero;
  logic        busy, done, erro;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  bcd_para_binario #(.DATA_W(32)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .sinal  (sinal),
    .centena(centena),
    .dezena (dezena),
    .unidade(unidade),
    .numero (numero),
    .busy   (busy),
    .done   (done),
    .erro   (erro)
  );

  initial forever #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input int c, input int d, input int u, input bit s);
    int v;
    v = c * 100 + d * 10 + u;
    return s ? 32'(-v) : 32'(v);
  endfunction

  // Drives a request and records its expected result; the caller steps through E0.
  task automatic drive(input int c, input int d, input int u, input bit s);
    centena = 4'(c);
    dezena  = 4'(d);
    unidade = 4'(u);
    sinal   = s;
    start   = 1'b1;
    exp_q.push_back(model(c, d, u, s));
  endtask

  // Waits (bounded) for done, then checks latency, busy and the scoreboard head.
  task automatic check_result(input string tag, input int exp_lat);
    int lat;
    bit busy_ok;
    lat     = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sb_pending"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) chk({tag, "_numero"}, numero, exp_q.pop_front());
  endtask

  initial begin
    int ndone;
    logic [31:0] prev;

    reset = 1'b1; start = 1'b0; sinal = 1'b0;
    centena = 4'd0; dezena = 4'd0; unidade = 4'd0;
    step(); step();
    reset = 1'b0;
    chk("rst_numero", numero, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 999 positive
    drive(9, 9, 9, 1'b0);
    step();
    start = 1'b0;
    chk("p999_busy_e0", {31'd0, busy}, 32'd1);
    check_result("p999", 11);
    step();
    chk("p999_done_fall", {31'd0, done}, 32'd0);

    // -0 gives 0
    drive(0, 0, 0, 1'b1);
    step();
    start = 1'b0;
    check_result("m000", 11);
    step();

    // -123
    drive(1, 2, 3, 1'b1);
    step();
    start = 1'b0;
    check_result("m123", 11);
    chk("m123_erro", {31'd0, erro}, 32'd0);
    step();

    // Rejected request: invalid tens digit
    prev = numero;
    centena = 4'd0; dezena = 4'd10; unidade = 4'd0; sinal = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("rej_done", {31'd0, done}, 32'd1);
    chk("rej_erro", {31'd0, erro}, 32'd1);
    chk("rej_busy", {31'd0, busy}, 32'd0);
    chk("rej_numero", numero, prev);
    step();
    chk("rej_done_fall", {31'd0, done}, 32'd0);
    chk("rej_erro_hold", {31'd0, erro}, 32'd1);

    // Blank code on hundreds is also rejected
    centena = 4'd11; dezena = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("blank_done", {31'd0, done}, 32'd1);
    chk("blank_busy", {31'd0, busy}, 32'd0);
    step();

    // Valid start clears erro
    drive(0, 4, 2, 1'b0);
    step();
    start = 1'b0;
    chk("p042_erro_clr", {31'd0, erro}, 32'd0);
    check_result("p042", 11);
    step();

    // Second start during conversion ignored, inputs changed mid-flight
    drive(5, 0, 0, 1'b0);
    step();
    start = 1'b0;
    step(); step();
    centena = 4'd0; dezena = 4'd0; unidade = 4'd1; start = 1'b1;
    step();
    start = 1'b0; centena = 4'd9; dezena = 4'd8; unidade = 4'd7; sinal = 1'b1;
    check_result("p500", 8);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    chk("p500_extra_done", 32'(ndone), 32'd0);
    chk("p500_hold", numero, 32'd500);

    // start held high: back-to-back conversions
    drive(3, 1, 4, 1'b0);
    step();
    check_result("b2b_1", 11);
    exp_q.push_back(model(3, 1, 4, 1'b0));
    step();
    chk("b2b_done_fall", {31'd0, done}, 32'd0);
    chk("b2b_busy_e12", {31'd0, busy}, 32'd1);
    start = 1'b0;
    check_result("b2b_2", 11);
    step();

    // Reset mid-conversion aborts it
    centena = 4'd7; dezena = 4'd7; unidade = 4'd7; sinal = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_numero", numero, 32'd0);
    chk("abort_erro", {31'd0, erro}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) ndone++;
      step();
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_numero_hold", numero, 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
